bcd_digit: RTL and testbench

- Converts an 8-bit unsigned binary value (0..255) to three BCD digits: ones, tens and hundreds.
- Outputs the one digit chosen by a digit-select counter.
- Sits between the score/value register and the multiplexed 7-segment display driver. The display scan counter drives `counter`.
- Leading-zero digits are replaced by a blank code so the display shows no leading zeros.

---
 rtl/bcd_digit.sv | 67 ++++++
 tb/tb_bcd_digit.sv | 101 ++++++++++
 2 files changed

// File: rtl/bcd_digit.sv
// Binary (0..255) to BCD digit selector for a multiplexed 7-segment display.
// Leading-zero positions and unused selects are driven with the BLANK code.
module bcd_digit #(
   parameter logic [7:0] BLANK      = 8'hFF,
   parameter int         NUM_DIGITS = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] ins,
   input  logic [2:0] counter,
   output logic [7:0] oneDigit
);

   localparam logic [2:0] NUM_SEL = 3'(NUM_DIGITS);

   logic [11:0] bcd_s;
   logic [7:0]  digit_s;
   logic [7:0]  one_digit_r;

   // Shift-add-3: any BCD nibble >= 5 is corrected before each left shift
   function automatic logic [11:0] bin_to_bcd(input logic [7:0] bin);
      logic [19:0] sh;
      sh = {12'd0, bin};
      for (int i = 0; i < 8; i++) begin
         if (sh[11:8] >= 4'd5) sh[11:8] = sh[11:8] + 4'd3;
         if (sh[15:12] >= 4'd5) sh[15:12] = sh[15:12] + 4'd3;
         if (sh[19:16] >= 4'd5) sh[19:16] = sh[19:16] + 4'd3;
         sh = sh << 1;
      end
      return sh[19:8];
   endfunction

   // Combinational conversion of the current input value
   always_comb begin
      bcd_s = bin_to_bcd(ins);
   end

   // Digit selection with leading-zero blanking
   always_comb begin
      digit_s = BLANK;
      if (counter < NUM_SEL) begin
         case (counter)
            3'd0: digit_s = {4'd0, bcd_s[3:0]};
            3'd1: begin
               if (ins > 8'd9) digit_s = {4'd0, bcd_s[7:4]};
               else            digit_s = BLANK;
            end
            3'd2: begin
               if (ins > 8'd99) digit_s = {4'd0, bcd_s[11:8]};
               else             digit_s = BLANK;
            end
            default: digit_s = BLANK;
         endcase
      end else begin
         digit_s = BLANK;
      end
   end

   // Output register, one cycle behind the sampled inputs
   always_ff @(posedge clk) begin
      if (reset) one_digit_r <= BLANK;
      else       one_digit_r <= digit_s;
   end

   assign oneDigit = one_digit_r;

endmodule

// File: tb/tb_bcd_digit.sv
// Directed and sweep bench for bcd_digit; each output is checked one cycle
// after its inputs were applied.
module tb_bcd_digit;

   logic       clk;
   logic       reset;
   logic [7:0] ins;
   logic [2:0] counter;
   logic [7:0] oneDigit;

   int errors = 0;
   int checks = 0;

   bcd_digit dut (
      .clk      (clk),
      .reset    (reset),
      .ins      (ins),
      .counter  (counter),
      .oneDigit (oneDigit)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] model(input int v, input int c);
      case (c)
         0:       return 8'(v % 10);
         1:       return (v > 9)  ? 8'((v / 10) % 10) : 8'hFF;
         2:       return (v > 99) ? 8'(v / 100)       : 8'hFF;
         default: return 8'hFF;
      endcase
   endfunction

   task automatic check(input string tag, input logic [7:0] exp);
      checks++;
      assert (oneDigit === exp)
      else begin
         errors++;
         $error("FAIL %s: oneDigit=%h expected=%h (ins=%0d counter=%0d)",
                tag, oneDigit, exp, ins, counter);
      end
   endtask

   task automatic step(input logic r, input logic [7:0] v, input logic [2:0] c,
                       input string tag, input logic [7:0] exp);
      reset   = r;
      ins     = v;
      counter = c;
      @(posedge clk);
      #1;
      check(tag, exp);
   endtask

   initial begin
      reset   = 1'b1;
      ins     = 8'd0;
      counter = 3'd0;
      #1;

      step(1'b1, 8'd123, 3'd0, "reset_cycle1", 8'hFF);
      step(1'b1, 8'd123, 3'd0, "reset_cycle2", 8'hFF);
      step(1'b0, 8'd123, 3'd0, "after_reset",  8'd3);
      step(1'b0, 8'd123, 3'd1, "123_tens",     8'd2);
      step(1'b0, 8'd123, 3'd2, "123_hund",     8'd1);

      step(1'b0, 8'd9,   3'd1, "9_tens_blank",   8'hFF);
      step(1'b0, 8'd10,  3'd1, "10_tens",        8'd1);
      step(1'b0, 8'd10,  3'd0, "10_ones",        8'd0);
      step(1'b0, 8'd99,  3'd2, "99_hund_blank",  8'hFF);
      step(1'b0, 8'd99,  3'd1, "99_tens",        8'd9);
      step(1'b0, 8'd100, 3'd2, "100_hund",       8'd1);
      step(1'b0, 8'd100, 3'd1, "100_tens",       8'd0);

      step(1'b0, 8'd255, 3'd0, "255_ones", 8'd5);
      step(1'b0, 8'd255, 3'd1, "255_tens", 8'd5);
      step(1'b0, 8'd255, 3'd2, "255_hund", 8'd2);
      step(1'b0, 8'd255, 3'd3, "255_sel3", 8'hFF);
      step(1'b0, 8'd255, 3'd7, "255_sel7", 8'hFF);

      step(1'b0, 8'd0, 3'd0, "0_ones", 8'd0);
      step(1'b0, 8'd0, 3'd1, "0_tens", 8'hFF);
      step(1'b0, 8'd0, 3'd2, "0_hund", 8'hFF);

      step(1'b0, 8'd47,  3'd0, "hold_a", 8'd7);
      step(1'b0, 8'd47,  3'd0, "hold_b", 8'd7);

      for (int v = 0; v < 256; v++) begin
         for (int c = 0; c < 8; c++) begin
            step(1'b0, 8'(v), 3'(c), "sweep", model(v, c));
         end
         if (v == 200) begin
            step(1'b1, 8'd200, 3'd2, "midreset",       8'hFF);
            step(1'b0, 8'd200, 3'd2, "after_midreset", 8'd2);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
